// File: rtl/soc_ctrl_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : soc_ctrl_rst_seq
// Purpose  : Power-on and soft-reset sequencer for the SoC clock/reset
//            domains, running on the always-on reference clock.
//            - Boot: releases each domain's active-low reset in index order;
//              each domain's clock-enable request follows GAP_CYCLES later,
//              and the next domain is released one cycle after that.
//            - Run : services sticky per-domain soft-reset requests, one
//              domain at a time, lowest index first:
//              gate clock -> assert reset -> release reset -> re-enable clock
//              -> one-cycle acknowledge.
// Ports    :
//   clk_i          in   1            reference clock (always running)
//   arst_i         in   1            asynchronous active-high reset
//   soft_rst_req_i in   NUM_DOMAINS  per-domain soft-reset request (sticky)
//   arst_no        out  NUM_DOMAINS  per-domain active-low reset to delay-gen
//   clk_en_o       out  NUM_DOMAINS  per-domain clock-enable request
//   soft_rst_ack_o out  NUM_DOMAINS  one-cycle pulse on soft-reset completion
//   done_o         out  1            boot sequence complete
//   busy_o         out  1            sequencer not idle in RUN
// Revision : 1.0 - initial release
// ============================================================================
module soc_ctrl_rst_seq #(
    parameter int NUM_DOMAINS = 2,
    parameter int GAP_CYCLES  = 64,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [NUM_DOMAINS-1:0] soft_rst_req_i,
    output logic [NUM_DOMAINS-1:0] arst_no,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] soft_rst_ack_o,
    output logic                   done_o,
    output logic                   busy_o
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int MAX_CYCLES = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // A timed state of length N exits on the edge where the counter reads N-1,
    // because the counter is zero during the first cycle after entry.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    // ------------------------------------------------------------------------
    // State encoding
    //   INIT   : held in reset; first edge afterwards releases domain 0
    //   REL    : boot only; the exit edge releases the next domain's reset
    //   GAP    : waiting between reset release and clock enable
    //   EN     : soft reset only; clock re-enabled, exit edge pulses the ack
    //   RUN    : idle, watching for pending soft-reset requests
    //   GATE   : clock gated, reset still released
    //   ASSERT : reset asserted with clock gated
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_REL    = 3'd1,
        S_GAP    = 3'd2,
        S_EN     = 3'd3,
        S_RUN    = 3'd4,
        S_GATE   = 3'd5,
        S_ASSERT = 3'd6
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [NUM_DOMAINS-1:0] pend_q,   pend_d;
    logic [NUM_DOMAINS-1:0] arst_n_q, arst_n_d;
    logic [NUM_DOMAINS-1:0] clk_en_q, clk_en_d;
    logic [NUM_DOMAINS-1:0] ack_q,    ack_d;
    logic                   done_q,   done_d;
    logic                   busy_q,   busy_d;

    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       nxt_idx;

    // ------------------------------------------------------------------------
    // Lowest-index pending request (fixed priority, index 0 highest)
    // ------------------------------------------------------------------------
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Next boot domain; REL is only reached while idx_q < NUM_DOMAINS-1.
    assign nxt_idx = idx_q + IDX_W'(1);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        arst_n_d = arst_n_q;
        clk_en_d = clk_en_q;
        ack_d    = '0;
        done_d   = done_q;
        // Requests are sticky in every non-reset state; a clear on the
        // acceptance edge below loses against a simultaneous new request.
        pend_d   = pend_q | soft_rst_req_i;

        unique case (state_q)
            S_INIT: begin
                idx_d       = '0;
                arst_n_d[0] = 1'b1;
                state_d     = S_GAP;
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    clk_en_d[idx_q] = 1'b1;
                    if (done_q) begin
                        // Soft-reset path: acknowledge on the next edge.
                        state_d = S_EN;
                    end else if (idx_q == LAST_IDX) begin
                        // Last boot domain: done rises with its clock enable.
                        done_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_REL;
                    end
                end
            end

            S_REL: begin
                idx_d             = nxt_idx;
                arst_n_d[nxt_idx] = 1'b1;
                state_d           = S_GAP;
            end

            S_EN: begin
                ack_d[idx_q] = 1'b1;
                state_d      = S_RUN;
            end

            S_RUN: begin
                if (|pend_q) begin
                    idx_d             = sel_idx;
                    clk_en_d[sel_idx] = 1'b0;
                    pend_d[sel_idx]   = soft_rst_req_i[sel_idx];
                    state_d           = S_GATE;
                end
            end

            S_GATE: begin
                if (cnt_q == HOLD_LAST) begin
                    arst_n_d[idx_q] = 1'b0;
                    state_d         = S_ASSERT;
                end
            end

            S_ASSERT: begin
                if (cnt_q == HOLD_LAST) begin
                    arst_n_d[idx_q] = 1'b1;
                    state_d         = S_GAP;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase

        // Counter restarts on every state change and only advances in the
        // timed states, so it can never wrap while idling in RUN.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_GAP) || (state_q == S_GATE) || (state_q == S_ASSERT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        busy_d = (state_d != S_RUN);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            arst_n_q <= '0;
            clk_en_q <= '0;
            ack_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            arst_n_q <= arst_n_d;
            clk_en_q <= clk_en_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign arst_no        = arst_n_q;
    assign clk_en_o       = clk_en_q;
    assign soft_rst_ack_o = ack_q;
    assign done_o         = done_q;
    assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_ctrl_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_ctrl_rst_seq
// Purpose  : Self-checking bench for soc_ctrl_rst_seq. A timeline model turns
//            boot and accepted soft-reset requests into expected output
//            transitions (cycle, signal bit, new value) held in a sorted
//            queue; a monitor pops one entry for every output bit that
//            changes and flags late, early, missing or unexpected changes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_ctrl_rst_seq;

    localparam int N  = 2;
    localparam int G  = 64;
    localparam int H  = 8;
    localparam int NB = 3 * N + 2;
    // Bit positions of the packed output vector {busy, done, ack, en, arst}
    localparam int K_ARST = 0;
    localparam int K_EN   = N;
    localparam int K_ACK  = 2 * N;
    localparam int K_DONE = 3 * N;
    localparam int K_BUSY = 3 * N + 1;
    localparam int NEVER  = 32'h3fff_ffff;

    typedef struct {
        int cyc;
        int key;
        bit val;
    } ev_t;

    logic         clk_i = 1'b0;
    logic         arst_i;
    logic [N-1:0] soft_rst_req_i;
    logic [N-1:0] arst_no;
    logic [N-1:0] clk_en_o;
    logic [N-1:0] soft_rst_ack_o;
    logic         done_o;
    logic         busy_o;

    int           checks = 0;
    int           errors = 0;
    int           n = 0;            // edges since the last reset release
    ev_t          exp_q[$];
    logic [N-1:0] m_pend = '0;
    int           m_run_since = NEVER;

    soc_ctrl_rst_seq #(
        .NUM_DOMAINS (N),
        .GAP_CYCLES  (G),
        .HOLD_CYCLES (H)
    ) dut (
        .clk_i          (clk_i),
        .arst_i         (arst_i),
        .soft_rst_req_i (soft_rst_req_i),
        .arst_no        (arst_no),
        .clk_en_o       (clk_en_o),
        .soft_rst_ack_o (soft_rst_ack_o),
        .done_o         (done_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void push_ev(input int cyc, input int key, input bit val);
        ev_t e;
        int  pos;
        e.cyc = cyc;
        e.key = key;
        e.val = val;
        pos   = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if ((exp_q[i].cyc > cyc) || ((exp_q[i].cyc == cyc) && (exp_q[i].key > key))) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
    endfunction

    // ------------------------------------------------------------------------
    // Reference timeline model: evaluated at every rising edge
    // ------------------------------------------------------------------------
    initial begin
        int a;
        int d;
        int e_k;
        forever begin
            @(posedge clk_i);
            if (arst_i) begin
                n           = 0;
                m_pend      = '0;
                m_run_since = NEVER;
                exp_q.delete();
            end else begin
                n = n + 1;
                if (n == 1) begin
                    // Boot: domain k released at 1 + k*(G+1), enabled G later.
                    for (int k = 0; k < N; k++) begin
                        e_k = 1 + k * (G + 1);
                        push_ev(e_k, K_ARST + k, 1'b1);
                        push_ev(e_k + G, K_EN + k, 1'b1);
                    end
                    e_k = 1 + (N - 1) * (G + 1) + G;
                    push_ev(e_k, K_DONE, 1'b1);
                    push_ev(e_k, K_BUSY, 1'b0);
                    m_run_since = e_k;
                end
                if ((n > m_run_since) && (m_pend != '0)) begin
                    d = 0;
                    while (!m_pend[d]) d++;
                    a = n;
                    push_ev(a,                 K_EN + d,   1'b0);
                    push_ev(a,                 K_BUSY,     1'b1);
                    push_ev(a + H,             K_ARST + d, 1'b0);
                    push_ev(a + 2 * H,         K_ARST + d, 1'b1);
                    push_ev(a + 2 * H + G,     K_EN + d,   1'b1);
                    push_ev(a + 2 * H + G + 1, K_ACK + d,  1'b1);
                    push_ev(a + 2 * H + G + 1, K_BUSY,     1'b0);
                    push_ev(a + 2 * H + G + 2, K_ACK + d,  1'b0);
                    m_run_since = a + 2 * H + G + 1;
                    m_pend[d]   = 1'b0;
                end
                m_pend = m_pend | soft_rst_req_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge, pops one event per changed bit
    // ------------------------------------------------------------------------
    initial begin
        logic [NB-1:0] cur_v;
        logic [NB-1:0] prev_v;
        ev_t           e;
        int            off_cnt;
        prev_v = '0;
        forever begin
            @(negedge clk_i);
            cur_v = {busy_o, done_o, soft_rst_ack_o, clk_en_o, arst_no};
            if (arst_i) begin
                checks++;
                if (cur_v !== {1'b1, 1'b0, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}}) begin
                    errors++;
                    $display("FAIL reset_hold: outputs {busy,done,ack,en,arst}=%b, required %b",
                             cur_v, {1'b1, 1'b0, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}});
                end
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (cur_v[i] !== prev_v[i]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_change: cycle %0d bit %0d -> %b, no change required",
                                     n, i, cur_v[i]);
                        end else begin
                            e = exp_q.pop_front();
                            if ((e.cyc != n) || (e.key != i) || (e.val !== cur_v[i])) begin
                                errors++;
                                $display("FAIL event: got cycle %0d bit %0d -> %b, required cycle %0d bit %0d -> %b",
                                         n, i, cur_v[i], e.cyc, e.key, e.val);
                            end
                        end
                    end
                end
                while ((exp_q.size() > 0) && (exp_q[0].cyc <= n)) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_change: at cycle %0d bit %0d still %b, required -> %b at cycle %0d",
                             n, e.key, cur_v[e.key], e.val, e.cyc);
                end
                // Invariants: no enabled clock under reset; at most one
                // domain away from fully-on once boot is done.
                checks++;
                off_cnt = 0;
                for (int d = 0; d < N; d++) begin
                    if (!(arst_no[d] && clk_en_o[d])) off_cnt++;
                end
                if (((~arst_no & clk_en_o) != '0) || (done_o && (off_cnt > 1))) begin
                    errors++;
                    $display("FAIL invariant: cycle %0d arst_no=%b clk_en_o=%b done_o=%b, required no en-under-reset and <=1 domain off",
                             n, arst_no, clk_en_o, done_o);
                end
            end
            prev_v = cur_v;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_edge(input int e);
        while (n < e) tick();
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 3000;
        while ((budget > 0) &&
               !((exp_q.size() == 0) && (m_pend == '0) && (n > m_run_since + 1))) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL %s: still busy after cycle budget (pending events %0d), required idle", tag, exp_q.size());
        end
    endtask

    // Request mask r is sampled on the next rising edge only.
    task automatic pulse_req(input logic [N-1:0] r);
        soft_rst_req_i = r;
        tick();
        soft_rst_req_i = '0;
    endtask

    task automatic async_reset_check(input string tag);
        arst_i = 1'b1;
        #2;
        checks++;
        if ((arst_no !== '0) || (clk_en_o !== '0) || (soft_rst_ack_o !== '0) ||
            (done_o !== 1'b0) || (busy_o !== 1'b1)) begin
            errors++;
            $display("FAIL %s: arst_no=%b clk_en_o=%b ack=%b done=%b busy=%b, required 0/0/0/0/1",
                     tag, arst_no, clk_en_o, soft_rst_ack_o, done_o, busy_o);
        end
        repeat (3) tick();
        arst_i = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int s;
        arst_i         = 1'b1;
        soft_rst_req_i = '0;
        repeat (3) tick();

        // Boot with a request for domain 0 sampled at edge 40
        arst_i = 1'b0;
        wait_edge(39);
        pulse_req(2'b01);
        wait_idle("boot_and_early_req");

        // Single request for domain 1
        pulse_req(2'b10);
        wait_idle("single_req_d1");

        // Both domains on one edge: two back-to-back sequences
        pulse_req(2'b11);
        wait_idle("dual_req");

        // Request on domain 1 held high for several edges (re-arm on accept edge)
        soft_rst_req_i = 2'b10;
        repeat (4) tick();
        soft_rst_req_i = '0;
        wait_idle("held_req");

        // Async reset in the GAP phase of a soft reset, with a request pending
        s = n + 1;
        pulse_req(2'b10);
        wait_edge(s + 1 + 2 * H + 20);
        soft_rst_req_i = 2'b01;
        tick();
        soft_rst_req_i = '0;
        async_reset_check("reset_mid_soft_gap");

        // Async reset during the rebooting sequence
        wait_edge(30);
        async_reset_check("reset_mid_boot");
        wait_idle("reboot");

        // Random request stress
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                soft_rst_req_i = N'($urandom_range(1, (1 << N) - 1));
            end else begin
                soft_rst_req_i = '0;
            end
            tick();
        end
        soft_rst_req_i = '0;
        wait_idle("stress_drain");

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_ctrl_rst_seq.md
Name: soc_ctrl_rst_seq

Overview:
Power-on and soft-reset sequencer for the SoC clock/reset domains, clocked by the always-on reference clock.
- Per domain, drives an active-low reset and a clock-enable request directly into that domain's clock/reset delay-gen stage (its arst_ni and clk_en_i).
- On boot, releases domains one at a time in index order. Each domain's clock enable is held off for a programmable gap after its reset release.
- After boot, services per-domain soft-reset requests with a gate, reset, release, re-enable sequence.

Parameters:
NUM_DOMAINS, 2, number of sequenced domains (>=1)
GAP_CYCLES, 64, cycles between a domain's reset release and its clock-enable assertion (>=1; must exceed the downstream delay-gen count of 50 plus its 2-flop enable pipeline)
HOLD_CYCLES, 8, cycles for each soft-reset phase: gate-before-reset and reset-assert (>=1)

Ports:
clk_i  input  1  reference clock (always running)
arst_i  input  1  asynchronous active-high reset
soft_rst_req_i  input  NUM_DOMAINS  per-domain soft-reset request; sampled each cycle, sticky once seen
arst_no  output  NUM_DOMAINS  per-domain active-low reset to the downstream delay-gen stage
clk_en_o  output  NUM_DOMAINS  per-domain clock-enable request to the downstream delay-gen stage
soft_rst_ack_o  output  NUM_DOMAINS  one-cycle pulse when that domain's soft reset completes
done_o  output  1  boot sequence complete
busy_o  output  1  sequencer not in RUN

Behaviour:
- Interface: one clock (clk_i); reset arst_i is asynchronous and active-high.
- All outputs are registered.
- While arst_i is high, and asynchronously on its assertion at any point:
  - arst_no = 0, clk_en_o = 0, soft_rst_ack_o = 0, done_o = 0, busy_o = 1.
  - Pending soft-reset bits are cleared; FSM goes to INIT.
- FSM states: INIT, REL, GAP, EN, RUN, GATE, ASSERT.
  - Counter width = $clog2(max(GAP_CYCLES, HOLD_CYCLES) + 1).
  - Counter clears on every state entry.
  - GAP, GATE and ASSERT each last exactly their parameter's cycle count.
- Boot timing (edge 1 = first rising clk_i edge after arst_i deasserts):
  - arst_no[0] rises at edge 1.
  - For domain k released at edge E_k: clk_en_o[k] rises at E_k+GAP_CYCLES, and arst_no[k+1] rises at E_k+GAP_CYCLES+1.
  - done_o rises together with clk_en_o[NUM_DOMAINS-1], then the FSM enters RUN; busy_o falls on that same edge.
  - Boot-phase soft_rst_ack_o stays 0.
- Pending bits:
  - pend[d] is set on any edge where soft_rst_req_i[d] = 1, in any state except reset. Requests during boot are held until RUN.
- Soft-reset acceptance:
  - In RUN with any pend bit set, the lowest set index d is accepted on the next edge: FSM goes to GATE and pend[d] is cleared.
  - If soft_rst_req_i[d] is high on that same edge, the set wins; pend[d] stays 1 and the domain is sequenced again afterward.
- Soft-reset timing for a domain accepted at edge A:
  - clk_en_o[d] falls at A.
  - arst_no[d] falls at A+HOLD_CYCLES.
  - arst_no[d] rises at A+2*HOLD_CYCLES.
  - clk_en_o[d] rises at A+2*HOLD_CYCLES+GAP_CYCLES. soft_rst_ack_o[d] is high for exactly the following cycle, and the FSM returns to RUN on that edge.
- During a soft reset:
  - busy_o = 1 from A until the return to RUN; done_o stays 1.
  - Other domains' arst_no and clk_en_o are untouched.
  - Only one domain is sequenced at a time.
- Invariants:
  - arst_no[d] = 0 implies clk_en_o[d] = 0 in every state.
  - clk_en_o never rises on the same edge as the same domain's arst_no rising.

Test Plan:
1. NUM_DOMAINS=2, GAP=64: release arst_i -> arst_no[0] at edge 1, clk_en_o[0] at edge 65, arst_no[1] at edge 66, clk_en_o[1] and done_o at edge 130, busy_o low from edge 130.
2. HOLD=8, GAP=64, in RUN: pulse soft_rst_req_i[1] sampled at edge 200 -> clk_en_o[1] falls 201, arst_no[1] falls 209, rises 217, clk_en_o[1] rises 281, soft_rst_ack_o[1] high for one cycle, domain 0 outputs constant throughout.
3. soft_rst_req_i = 2'b11 on one edge in RUN -> domain 0 sequenced first, domain 1 starts on the edge after domain 0's return to RUN, two separate ack pulses.
4. soft_rst_req_i[0] pulsed at edge 40 during boot -> no effect until RUN, then domain 0 soft sequence starts on the edge after done_o rises.
5. Assert arst_i mid-GAP of a soft reset (and again mid-boot) -> all outputs immediately at reset values, pend cleared; after release the full boot sequence repeats from edge 1 with no stale ack.
6. Assertion check over a random request stress: never (arst_no[d]==0 && clk_en_o[d]==1), and at most one domain is outside the fully-on state while done_o=1.
